// File: rtl/bus_master_pkg.sv
// Shared definitions for the bus master: data width, wait-counter width and
// the 2-bit FSM state encoding.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package bus_master_pkg;
    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10,
        TURN  = 2'b11
    } state_e;
endpackage

// File: rtl/bus_master_driver.sv
// Tristate driver for the shared data bus: drives din while en is high,
// otherwise releases the bus.
module bus_driver #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output wire  [WIDTH-1:0] data
);
    assign data = en ? din : {WIDTH{1'bz}};
endmodule

// File: rtl/bus_master.sv
// Single-request bus master for an asynchronous-style target with CS/EN/OE
// strobes, programmable wait states and a one-cycle read turnaround.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  busy,
    output logic                  CS,
    output logic                  EN,
    output logic                  OE,
    inout  wire  [DATA_WIDTH-1:0] data
);
    localparam logic [CNT_WIDTH-1:0] WAIT_LD = CNT_WIDTH'(WAIT_CYCLES);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    cs_q, cs_d;
    logic                    en_q, en_d;
    logic                    oe_q, oe_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            cs_q     <= 1'b0;
            en_q     <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            cs_q     <= cs_d;
            en_q     <= en_d;
            oe_q     <= oe_d;
        end
    end

    // Strobes are computed one cycle ahead so they leave the block registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        cs_d     = cs_q;
        en_d     = en_q;
        oe_d     = oe_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_LD;
                    cs_d    = 1'b1;
                    if (req_we) begin
                        state_d = WRITE;
                        en_d    = 1'b1;
                    end else begin
                        state_d = READ;
                        oe_d    = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cs_d    = 1'b0;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    state_d  = TURN;
                    rdata_d  = data;
                    rvalid_d = 1'b1;
                    cs_d     = 1'b0;
                    oe_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign CS        = cs_q;
    assign EN        = en_q;
    assign OE        = oe_q;

    // The master only ever owns the bus while in WRITE.
    bus_driver #(
        .WIDTH (DATA_WIDTH)
    ) u_bus_driver (
        .en   (state_q == WRITE),
        .din  (wdata_q),
        .data (data)
    );
endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: WAIT_CYCLES=0 and =2 instances side by side, each with
// its own target register, checked against a transaction-level model.
module tb_bus_master;
    import bus_master_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_we = 1'b0;
    logic [DATA_WIDTH-1:0] req_wdata = '0;

    logic [1:0]            ready_w, rvalid_w, busy_w, cs_w, en_w, oe_w;
    logic [DATA_WIDTH-1:0] rdata_w [2];
    wire  [DATA_WIDTH-1:0] bus0, bus1;
    logic [DATA_WIDTH-1:0] tgt_q [2] = '{8'h00, 8'h00};

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bus_master #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_wdata(req_wdata), .req_ready(ready_w[0]), .rdata(rdata_w[0]),
        .rvalid(rvalid_w[0]), .busy(busy_w[0]), .CS(cs_w[0]), .EN(en_w[0]),
        .OE(oe_w[0]), .data(bus0)
    );

    bus_master #(.WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_wdata(req_wdata), .req_ready(ready_w[1]), .rdata(rdata_w[1]),
        .rvalid(rvalid_w[1]), .busy(busy_w[1]), .CS(cs_w[1]), .EN(en_w[1]),
        .OE(oe_w[1]), .data(bus1)
    );

    // Target devices: drive their register on CS&OE, latch the bus on CS&EN.
    assign bus0 = (cs_w[0] && oe_w[0]) ? tgt_q[0] : 8'bz;
    assign bus1 = (cs_w[1] && oe_w[1]) ? tgt_q[1] : 8'bz;

    always @(posedge clk) begin
        if (cs_w[0] && en_w[0]) tgt_q[0] <= bus0;
        if (cs_w[1] && en_w[1]) tgt_q[1] <= bus1;
    end

    // Model: pos counts cycles since acceptance (-1 = idle). A transaction
    // strobes for wait+1 cycles; a read adds one more cycle with rvalid.
    int                    wcyc  [2] = '{0, 2};
    int                    pos   [2] = '{-1, -1};
    bit                    m_we  [2] = '{1'b0, 1'b0};
    logic [DATA_WIDTH-1:0] m_wd  [2] = '{8'h00, 8'h00};
    logic [DATA_WIDTH-1:0] m_rd  [2] = '{8'h00, 8'h00};
    logic [DATA_WIDTH-1:0] m_tgt [2] = '{8'h00, 8'h00};

    task automatic chk(input string name, input int k,
                       input logic [DATA_WIDTH-1:0] act, input logic [DATA_WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
    endtask

    task automatic chk_float(input int k, input logic [DATA_WIDTH-1:0] b);
        n_total++;
        if ($isunknown(b) || b == '0) n_pass++;
        else $display("FAIL bus_released inst%0d: got %0h, expected undriven (t=%0t)", k, b, $time);
    endtask

    task automatic model_adv(input int k, input logic r, v, we, input logic [DATA_WIDTH-1:0] wd);
        if (pos[k] >= 0 && pos[k] <= wcyc[k] && m_we[k]) m_tgt[k] = m_wd[k];
        if (r) begin
            pos[k]  = -1;
            m_rd[k] = '0;
        end else if (pos[k] < 0) begin
            if (v) begin
                pos[k]  = 0;
                m_we[k] = we;
                m_wd[k] = wd;
            end
        end else begin
            pos[k]++;
            if (pos[k] == wcyc[k] + 1) begin
                if (m_we[k]) pos[k] = -1;
                else m_rd[k] = m_tgt[k];
            end else if (pos[k] == wcyc[k] + 2) begin
                pos[k] = -1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic                  idle, strobe, turn;
            logic [DATA_WIDTH-1:0] b;
            idle   = (pos[k] < 0);
            strobe = (pos[k] >= 0) && (pos[k] <= wcyc[k]);
            turn   = !m_we[k] && (pos[k] == wcyc[k] + 1);
            b      = (k == 0) ? bus0 : bus1;
            chk("req_ready", k, 8'(ready_w[k]), 8'(idle && !reset));
            chk("busy",      k, 8'(busy_w[k]),  8'(!idle));
            chk("CS",        k, 8'(cs_w[k]),    8'(strobe));
            chk("EN",        k, 8'(en_w[k]),    8'(strobe && m_we[k]));
            chk("OE",        k, 8'(oe_w[k]),    8'(strobe && !m_we[k]));
            chk("rvalid",    k, 8'(rvalid_w[k]), 8'(turn));
            chk("rdata",     k, rdata_w[k],     m_rd[k]);
            if (strobe && m_we[k])       chk("bus_wdata", k, b, m_wd[k]);
            else if (strobe && !m_we[k]) chk("bus_read", k, b, m_tgt[k]);
            else                         chk_float(k, b);
        end
    endtask

    task automatic step(input logic r, v, we, input logic [DATA_WIDTH-1:0] wd);
        reset     = r;
        req_valid = v;
        req_we    = we;
        req_wdata = wd;
        for (int k = 0; k < 2; k++) model_adv(k, r, v, we, wd);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic                  r, v, we;
        logic [DATA_WIDTH-1:0] wd;
        logic                  e_ready, e_busy, e_cs, e_en, e_oe, e_rv;
        logic [DATA_WIDTH-1:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic r, v, we, input logic [7:0] wd,
                                 input logic rdy, bsy, cs, en, oe, rv, input logic [7:0] rd);
        vec_t t;
        t.r = r; t.v = v; t.we = we; t.wd = wd;
        t.e_ready = rdy; t.e_busy = bsy; t.e_cs = cs; t.e_en = en;
        t.e_oe = oe; t.e_rv = rv; t.e_rd = rd;
        return t;
    endfunction

    initial begin
        // Expected outputs of the WAIT_CYCLES=0 instance after each cycle.
        //                r  v  we wd      rdy bsy cs en oe rv rd
        tbl.push_back(mkv(1, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(0, 1, 1, 8'hBF,  0, 1, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(0, 1, 0, 8'h00,  0, 1, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  0, 1, 0, 0, 0, 1, 8'hBF));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'hBF));
        tbl.push_back(mkv(0, 1, 1, 8'hAD,  0, 1, 1, 1, 0, 0, 8'hBF));
        tbl.push_back(mkv(0, 1, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'hBF));
        tbl.push_back(mkv(0, 1, 0, 8'h00,  0, 1, 1, 0, 1, 0, 8'hBF));
        tbl.push_back(mkv(0, 1, 1, 8'h23,  0, 1, 0, 0, 0, 1, 8'hAD));
        tbl.push_back(mkv(0, 1, 1, 8'h23,  1, 0, 0, 0, 0, 0, 8'hAD));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'hAD));
        tbl.push_back(mkv(0, 1, 0, 8'h00,  0, 1, 1, 0, 1, 0, 8'hAD));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  0, 1, 0, 0, 0, 1, 8'hAD));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'hAD));
        tbl.push_back(mkv(0, 1, 0, 8'h00,  0, 1, 1, 0, 1, 0, 8'hAD));
        tbl.push_back(mkv(1, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(0, 1, 1, 8'hFF,  0, 1, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mkv(0, 1, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(0, 1, 0, 8'h00,  0, 1, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  0, 1, 0, 0, 0, 1, 8'hFF));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'hFF));
        tbl.push_back(mkv(0, 1, 1, 8'h5A,  0, 1, 1, 1, 0, 0, 8'hFF));
        tbl.push_back(mkv(1, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 8'h00));

        repeat (2) @(posedge clk);
        @(negedge clk);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].we, tbl[i].wd);
            chk($sformatf("vec%0d_ready", i), 0, 8'(ready_w[0]), 8'(tbl[i].e_ready));
            chk($sformatf("vec%0d_busy", i),  0, 8'(busy_w[0]),  8'(tbl[i].e_busy));
            chk($sformatf("vec%0d_CS", i),    0, 8'(cs_w[0]),    8'(tbl[i].e_cs));
            chk($sformatf("vec%0d_EN", i),    0, 8'(en_w[0]),    8'(tbl[i].e_en));
            chk($sformatf("vec%0d_OE", i),    0, 8'(oe_w[0]),    8'(tbl[i].e_oe));
            chk($sformatf("vec%0d_rvalid", i), 0, 8'(rvalid_w[0]), 8'(tbl[i].e_rv));
            chk($sformatf("vec%0d_rdata", i), 0, rdata_w[0],     tbl[i].e_rd);
        end

        // Three-cycle write then read on the WAIT_CYCLES=2 instance.
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 1, 1, 8'h67);
        for (int c = 0; c < 3; c++) begin
            chk("w2_write_CS", 1, 8'(cs_w[1]), 8'h01);
            chk("w2_write_EN", 1, 8'(en_w[1]), 8'h01);
            chk("w2_write_bus", 1, bus1, 8'h67);
            step(0, 0, 0, 8'h00);
        end
        chk("w2_write_done_CS", 1, 8'(cs_w[1]), 8'h00);
        step(0, 1, 0, 8'h00);
        for (int c = 1; c <= 3; c++) begin
            step(0, 0, 0, 8'h00);
            chk($sformatf("w2_rvalid_c%0d", c), 1, 8'(rvalid_w[1]), 8'((c == 3) ? 1 : 0));
        end
        chk("w2_rdata", 1, rdata_w[1], 8'h67);
        step(0, 0, 0, 8'h00);

        // Random traffic with occasional resets, checked by the model each cycle.
        for (int i = 0; i < 600; i++) begin
            logic                  r, v, we;
            logic [DATA_WIDTH-1:0] wd;
            r  = ($urandom_range(0, 39) == 0);
            v  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            wd = 8'($urandom_range(1, 255));
            step(r, v, we, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
